// File: rtl/lcd_char_writer_if.sv
// Character stream into the LCD writer: one ASCII byte per valid/ready handshake.
// A byte transfers on the rising clk edge where char_valid && char_ready. The source holds
// char_data stable while char_valid is high, and char_ready may depend combinationally on other inputs.
interface lcd_char_writer_if;
  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready;

  modport master (output char_data, output char_valid, input char_ready);
  modport slave  (input char_data, input char_valid, output char_ready);
endinterface

// File: rtl/lcd_char_writer.sv
// HD44780 8-bit write-only character driver: power-up init, E-pulse timing, column tracking, clear.
// Optional LCD_AUTO_WRAP_EN: emits DDRAM address commands when the column reaches 16 or wraps to 0.
module lcd_char_writer #(
  parameter int SETUP_CYCLES      = 2,
  parameter int E_PULSE_CYCLES    = 12,
  parameter int CMD_WAIT_CYCLES   = 2500,
  parameter int CLEAR_WAIT_CYCLES = 100000,
  parameter int POWERUP_CYCLES    = 750000
) (
  input  logic                clk,
  input  logic                reset,
  lcd_char_writer_if.slave    chr,
  input  logic                clear_req,
  output logic                busy,
  output logic                lcd_rs,
  output logic                lcd_rw,
  output logic                lcd_e,
  output logic [7:0]          lcd_db,
  output logic [4:0]          col,
  output logic [1:0]          init_idx,
  output logic [2:0]          fsm_state
);

  localparam int MAX_A = (SETUP_CYCLES > E_PULSE_CYCLES) ? SETUP_CYCLES : E_PULSE_CYCLES;
  localparam int MAX_B = (CMD_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ? CMD_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_CYC = (MAX_C > POWERUP_CYCLES) ? MAX_C : POWERUP_CYCLES;
  localparam int CW = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_POWERUP = 3'd0,
    S_INIT    = 3'd1,
    S_IDLE    = 3'd2,
    S_SETUP   = 3'd3,
    S_PULSE   = 3'd4,
    S_WAIT    = 3'd5
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] wait_last;
  logic          init_done;
  logic [4:0]    col_next;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  endfunction

  // The clear command needs the long execution time; everything else uses the short one.
  always_comb begin
    wait_last = CW'(CMD_WAIT_CYCLES - 1);
    if (!lcd_rs && lcd_db == 8'h01) wait_last = CW'(CLEAR_WAIT_CYCLES - 1);
  end

  assign col_next       = col + 5'd1;
  assign chr.char_ready = (state == S_IDLE) && !clear_req;
  assign busy           = (state != S_IDLE);
  assign lcd_rw         = 1'b0;
  assign fsm_state      = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_POWERUP;
      cnt       <= '0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_db    <= 8'h00;
      col       <= 5'd0;
      init_idx  <= 2'd0;
      init_done <= 1'b0;
    end else begin
      case (state)
        S_POWERUP: begin
          if (cnt == CW'(POWERUP_CYCLES - 1)) begin
            cnt   <= '0;
            state <= S_INIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_INIT: begin
          lcd_rs <= 1'b0;
          lcd_db <= init_byte(init_idx);
          cnt    <= '0;
          state  <= S_SETUP;
        end
        S_IDLE: begin
          cnt <= '0;
          if (clear_req) begin
            lcd_rs <= 1'b0;
            lcd_db <= 8'h01;
            col    <= 5'd0;
            state  <= S_SETUP;
          end else if (chr.char_valid) begin
            lcd_rs <= 1'b1;
            lcd_db <= chr.char_data;
            state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == CW'(SETUP_CYCLES - 1)) begin
            cnt   <= '0;
            lcd_e <= 1'b1;
            state <= S_PULSE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PULSE: begin
          if (cnt == CW'(E_PULSE_CYCLES - 1)) begin
            cnt   <= '0;
            lcd_e <= 1'b0;
            state <= S_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt == wait_last) begin
            cnt <= '0;
            if (!init_done) begin
              if (init_idx == 2'd3) begin
                init_done <= 1'b1;
                col       <= 5'd0;
                state     <= S_IDLE;
              end else begin
                init_idx <= init_idx + 2'd1;
                state    <= S_INIT;
              end
            end else if (lcd_rs) begin
              col <= col_next;
`ifdef LCD_AUTO_WRAP_EN
              // Address commands go straight to SETUP so busy never drops in between.
              if (col_next == 5'd16) begin
                lcd_rs <= 1'b0;
                lcd_db <= 8'hC0;
                state  <= S_SETUP;
              end else if (col_next == 5'd0) begin
                lcd_rs <= 1'b0;
                lcd_db <= 8'h80;
                state  <= S_SETUP;
              end else begin
                state <= S_IDLE;
              end
`else
              state <= S_IDLE;
`endif
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_POWERUP;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_char_writer.sv
// Directed bench for lcd_char_writer: init sequence, data writes, clear priority, column wrap, reset abort.
module tb_lcd_char_writer;
  localparam int SETUP = 1;
  localparam int EPULSE = 2;
  localparam int CMDW = 3;
  localparam int CLRW = 5;
  localparam int PWR = 10;
  // Samples after reset release until char_ready: 10 + 4*(1+1+2) + 3*3 + 5
  localparam int INIT_LAT = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear_req = 1'b0;
  logic       busy, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_db;
  logic [4:0] col;
  logic [1:0] init_idx;
  logic [2:0] fsm_state;

  lcd_char_writer_if chr_if ();

  lcd_char_writer #(
    .SETUP_CYCLES(SETUP), .E_PULSE_CYCLES(EPULSE), .CMD_WAIT_CYCLES(CMDW),
    .CLEAR_WAIT_CYCLES(CLRW), .POWERUP_CYCLES(PWR)
  ) dut (
    .clk(clk), .reset(reset), .chr(chr_if), .clear_req(clear_req), .busy(busy),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db),
    .col(col), .init_idx(init_idx), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // scoreboard: {wait_cycles[3:0], rs, db[7:0]} per expected E pulse
  logic [12:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] mk(input int wt, input logic rs, input logic [7:0] db);
    return {4'(wt), rs, db};
  endfunction

  task automatic push_init();
    exp_q.push_back(mk(CMDW, 1'b0, 8'h38));
    exp_q.push_back(mk(CMDW, 1'b0, 8'h0C));
    exp_q.push_back(mk(CLRW, 1'b0, 8'h01));
    exp_q.push_back(mk(CMDW, 1'b0, 8'h06));
  endtask

  // Pulse monitor: captures RS/DB at E rise, E width, and cycles spent in WAIT afterwards.
  int          mon_phase = 0;
  int          e_w = 0;
  int          w = 0;
  int          rs0_cnt = 0;
  int          rs1_cnt = 0;
  logic [8:0]  cap;
  logic [12:0] ent;

  always @(negedge clk) begin
    if (reset) begin
      mon_phase = 0;
    end else begin
      case (mon_phase)
        0: if (lcd_e) begin
             cap = {lcd_rs, lcd_db};
             e_w = 1;
             mon_phase = 1;
           end
        1: if (lcd_e) e_w++;
           else begin
             w = (fsm_state == 3'd5) ? 1 : 0;
             mon_phase = 2;
           end
        default: if (fsm_state == 3'd5) w++;
           else begin
             if (cap[8]) rs1_cnt++; else rs0_cnt++;
             if (exp_q.size() == 0) begin
               check("spurious_pulse", {23'd0, cap}, 32'h0);
             end else begin
               ent = exp_q.pop_front();
               check("pulse_rs_db", {23'd0, cap}, {23'd0, ent[8:0]});
               check("e_width", e_w, EPULSE);
               check("wait_len", w, {28'd0, ent[12:9]});
             end
             mon_phase = 0;
           end
      endcase
    end
  end

  // driver tasks
  task automatic powerup_check(input string tag);
    int n = 0;
    int early_e = 0;
    push_init();
    reset = 1'b0;
    while (!chr_if.char_ready && n < 500) begin
      @(negedge clk);
      n++;
      if (n <= PWR && lcd_e) early_e++;
    end
    check({tag, "_quiet"}, early_e, 0);
    check({tag, "_latency"}, n, INIT_LAT);
    repeat (2) @(negedge clk);
    check({tag, "_drain"}, exp_q.size(), 0);
    check({tag, "_col"}, {27'd0, col}, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    int n = 0;
    chr_if.char_data = b;
    chr_if.char_valid = 1'b1;
    while (!chr_if.char_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!chr_if.char_ready) check("accept_timeout", 0, 1);
    acc_cyc = cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, busy}, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_clear();
    clear_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear_req = 1'b0;
  endtask

  int t0, t1, t2, t3;
  int rs0_base;

  initial begin
    chr_if.char_valid = 1'b0;
    chr_if.char_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_lcd_e", {31'd0, lcd_e}, 0);
    check("rst_lcd_rs", {31'd0, lcd_rs}, 0);
    check("rst_lcd_rw", {31'd0, lcd_rw}, 0);
    check("rst_lcd_db", {24'd0, lcd_db}, 0);
    check("rst_ready", {31'd0, chr_if.char_ready}, 0);
    check("rst_busy", {31'd0, busy}, 1);
    check("rst_col", {27'd0, col}, 0);
    check("rst_init_idx", {30'd0, init_idx}, 0);
    check("rst_state", {29'd0, fsm_state}, 0);

    powerup_check("powerup");

    // "Fail" with char_valid held across all four bytes
    exp_q.push_back(mk(CMDW, 1'b1, 8'h46));
    exp_q.push_back(mk(CMDW, 1'b1, 8'h61));
    exp_q.push_back(mk(CMDW, 1'b1, 8'h69));
    exp_q.push_back(mk(CMDW, 1'b1, 8'h6C));
    send_byte(8'h46, t0);
    send_byte(8'h61, t1);
    send_byte(8'h69, t2);
    send_byte(8'h6C, t3);
    chr_if.char_valid = 1'b0;
    check("accept_gap_1", t1 - t0, 7);
    check("accept_gap_2", t2 - t1, 7);
    check("accept_gap_3", t3 - t2, 7);
    wait_idle("fail_idle");
    check("fail_drain", exp_q.size(), 0);
    check("fail_col", {27'd0, col}, 4);
    check("fail_rs1_pulses", rs1_cnt, 4);

    // clear_req and a character in the same IDLE cycle
    exp_q.push_back(mk(CLRW, 1'b0, 8'h01));
    exp_q.push_back(mk(CMDW, 1'b1, 8'h41));
    chr_if.char_data = 8'h41;
    chr_if.char_valid = 1'b1;
    clear_req = 1'b1;
    #1;
    check("clear_blocks_ready", {31'd0, chr_if.char_ready}, 0);
    @(posedge clk);
    @(negedge clk);
    clear_req = 1'b0;
    check("clear_busy", {31'd0, busy}, 1);
    send_byte(8'h41, t0);
    chr_if.char_valid = 1'b0;
    wait_idle("clear_idle");
    check("clear_drain", exp_q.size(), 0);
    check("clear_col", {27'd0, col}, 1);

    // 32 characters from column 0
    exp_q.push_back(mk(CLRW, 1'b0, 8'h01));
    pulse_clear();
    wait_idle("wrap_clear_idle");
    check("wrap_start_col", {27'd0, col}, 0);
    rs0_base = rs0_cnt;
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(mk(CMDW, 1'b1, 8'h30 + 8'(i)));
`ifdef LCD_AUTO_WRAP_EN
      if (i == 15) exp_q.push_back(mk(CMDW, 1'b0, 8'hC0));
      if (i == 31) exp_q.push_back(mk(CMDW, 1'b0, 8'h80));
`endif
      send_byte(8'h30 + 8'(i), t0);
    end
    chr_if.char_valid = 1'b0;
    wait_idle("wrap_idle");
    check("wrap_drain", exp_q.size(), 0);
    check("wrap_col", {27'd0, col}, 0);
`ifdef LCD_AUTO_WRAP_EN
    check("wrap_cmd_pulses", rs0_cnt - rs0_base, 2);
`else
    check("wrap_cmd_pulses", rs0_cnt - rs0_base, 0);
`endif

    // clear_req while busy is dropped
    rs0_base = rs0_cnt;
    exp_q.push_back(mk(CMDW, 1'b1, 8'h42));
    send_byte(8'h42, t0);
    pulse_clear();
    chr_if.char_valid = 1'b0;
    wait_idle("busy_clear_idle");
    check("busy_clear_drain", exp_q.size(), 0);
    check("busy_clear_no_cmd", rs0_cnt - rs0_base, 0);
    check("busy_clear_col", {27'd0, col}, 1);

    // reset during the E pulse of a data write
    begin
      int n = 0;
      chr_if.char_data = 8'h43;
      chr_if.char_valid = 1'b1;
      while (!lcd_e && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("abort_pulse_seen", {31'd0, lcd_e}, 1);
      chr_if.char_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("abort_lcd_e", {31'd0, lcd_e}, 0);
      check("abort_busy", {31'd0, busy}, 1);
      check("abort_ready", {31'd0, chr_if.char_ready}, 0);
      check("abort_state", {29'd0, fsm_state}, 0);
      check("abort_col", {27'd0, col}, 0);
      @(negedge clk);
      @(negedge clk);
      check("abort_queue_empty", exp_q.size(), 0);
      powerup_check("repower");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
